// File: rtl/rom_pkg.sv
// rom_pkg: shared types and default widths for the ROM streaming reader.
package rom_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int CNT_W_DEF  = 3;
  localparam int SUM_W_DEF  = 11;
  localparam int ROM_DEPTH  = 2 ** ADDR_W_DEF;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: sequences bursts from a combinational ROM into a registered valid/ready stream with checksum.
module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  checksum
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                xfer;

  assign xfer = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = start_addr;
        rem_d   = count;
        sum_d   = '0;
        state_d = (count != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        data_d  = rom_data;
        valid_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (xfer) begin
        sum_d   = sum_q + SUM_W'(data_q);
        valid_d = 1'b0;
        rem_d   = rem_q - 1'b1;
        addr_d  = (rem_q == CNT_W'(1)) ? addr_q : addr_q + 1'b1;
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_cs    = state_q == S_READ;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign checksum  = sum_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: scoreboard bench pairing the reader with a 4x8 ROM holding 01..04.
module tb_rom_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  start_addr = '0;
  logic [2:0]  count = '0;
  logic [7:0]  rom_data;
  logic [1:0]  rom_addr;
  logic        rom_cs;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [10:0] checksum;

  logic [7:0] rom_mem [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  assign rom_data = rom_cs ? rom_mem[rom_addr] : 8'h00;

  rom_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .rom_data(rom_data), .rom_addr(rom_addr), .rom_cs(rom_cs), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [1:0] exp_addr [$];
  logic [7:0] exp_data [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (rom_cs) begin
        if (exp_addr.size() == 0) chk("unexpected rom_cs", 1, 0);
        else chk("rom_addr", int'(rom_addr), int'(exp_addr.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) chk("unexpected transfer", 1, 0);
        else chk("out_data", int'(out_data), int'(exp_data.pop_front()));
      end
    end
  end

  task automatic go(input logic [1:0] a, input logic [2:0] n, input logic [7:0] words [$]);
    logic [1:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + 2'(i);
      exp_addr.push_back(t);
      exp_data.push_back(words[i]);
    end
    done_cnt = 0;
    start = 1'b1; start_addr = a; count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_burst(input string name, input int sum);
    int k = 0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk({name, " done seen"}, int'(done), 1);
    @(posedge clk); #1;
    chk({name, " done pulses"}, done_cnt, 1);
    chk({name, " busy after"}, int'(busy), 0);
    chk({name, " checksum"}, int'(checksum), sum);
    chk({name, " queues drained"}, exp_addr.size() + exp_data.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk({name, " valid seen"}, int'(out_valid), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset checksum", int'(checksum), 0);
    chk("reset rom_cs", int'(rom_cs), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    out_ready = 1'b1;
    go(2'd0, 3'd4, '{8'h01, 8'h02, 8'h03, 8'h04});
    chk("full valid after 1 edge", int'(out_valid), 0);
    chk("full busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("full valid after 2 edges", int'(out_valid), 1);
    chk("full first word", int'(out_data), 8'h01);
    finish_burst("full", 10);

    go(2'd3, 3'd3, '{8'h04, 8'h01, 8'h02});
    finish_burst("wrap", 7);

    out_ready = 1'b0;
    go(2'd1, 3'd2, '{8'h02, 8'h03});
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp held valid", int'(out_valid), 1);
      chk("bp held data", int'(out_data), 8'h02);
      chk("bp rom_cs low", int'(rom_cs), 0);
    end
    out_ready = 1'b1;
    finish_burst("bp", 5);

    go(2'd2, 3'd0, '{8'h00});
    chk("zero no valid", int'(out_valid), 0);
    finish_burst("zero", 0);

    go(2'd0, 3'd4, '{8'h01, 8'h02, 8'h03, 8'h04});
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 2'd2; count = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_burst("busy start", 10);

    out_ready = 1'b0;
    go(2'd0, 3'd2, '{8'h01, 8'h02});
    wait_valid("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst checksum", int'(checksum), 0);
    chk("rst rom_addr", int'(rom_addr), 0);
    out_ready = 1'b1;
    go(2'd2, 3'd1, '{8'h03});
    finish_burst("after rst", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
